ras_ckpt_stack: RTL

// - Parametrised return address stack (RAS) for the superscalar IF stage, next generation of the fixed 8-deep RAS.
// - Circular storage of RAS_DEPTH return PCs; pushes on predicted calls, pops on predicted returns.
// - Wraps on overflow, reports underflow, supports push+pop in the same cycle.
// - Optional per-ticket checkpoint/restore repairs speculative corruption after a misprediction.

---
 rtl/ras_ckpt_stack.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ras_ckpt_stack.sv
// Circular return address stack with flush, overflow/underflow pulses and optional
// per-ticket checkpoint/restore, enabled by defining RAS_CKPT_EN.
module ras_ckpt_stack #(
  parameter int PC_BITS     = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int TICKET_NUM  = 8,
  parameter int CNT_BITS    = $clog2(RAS_DEPTH + 1),
  parameter int TICKET_BITS = $clog2(TICKET_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [PC_BITS-1:0]     push_addr_i,
  input  logic                   pop_i,
  input  logic                   ckpt_save_i,
  input  logic [TICKET_BITS-1:0] ckpt_save_id_i,
  input  logic                   ckpt_restore_i,
  input  logic [TICKET_BITS-1:0] ckpt_restore_id_i,
  output logic [PC_BITS-1:0]     top_addr_o,
  output logic                   top_valid_o,
  output logic [CNT_BITS-1:0]    count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int PTR_BITS = $clog2(RAS_DEPTH);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(RAS_DEPTH);

  logic [PC_BITS-1:0]  entry_q [RAS_DEPTH];
  logic [PTR_BITS-1:0] tos_q;
  logic [CNT_BITS-1:0] count_q;
  logic                overflow_q;
  logic                underflow_q;

  logic [PTR_BITS-1:0] tos_inc;
  logic [PTR_BITS-1:0] tos_dec;
  logic                do_flush;
  logic                do_restore;
  logic                do_replace;
  logic                do_push;
  logic                do_pop;
  logic [PTR_BITS-1:0] rest_tos;
  logic [CNT_BITS-1:0] rest_cnt;
  logic [PC_BITS-1:0]  rest_top;

  assign tos_inc = tos_q + 1'b1;
  assign tos_dec = tos_q - 1'b1;

`ifdef RAS_CKPT_EN
  logic [PTR_BITS-1:0] ck_tos_q [TICKET_NUM];
  logic [CNT_BITS-1:0] ck_cnt_q [TICKET_NUM];
  logic [PC_BITS-1:0]  ck_top_q [TICKET_NUM];

  assign do_flush   = flush_i;
  assign do_restore = ckpt_restore_i & ~flush_i;
  assign rest_tos   = ck_tos_q[ckpt_restore_id_i];
  assign rest_cnt   = ck_cnt_q[ckpt_restore_id_i];
  assign rest_top   = ck_top_q[ckpt_restore_id_i];

  // Snapshot is taken from pre-update state, so a same-cycle push/pop is not captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TICKET_NUM; i++) begin
        ck_tos_q[i] <= '0;
        ck_cnt_q[i] <= '0;
        ck_top_q[i] <= '0;
      end
    end else if (ckpt_save_i && !flush_i && !ckpt_restore_i) begin
      ck_tos_q[ckpt_save_id_i] <= tos_q;
      ck_cnt_q[ckpt_save_id_i] <= count_q;
      ck_top_q[ckpt_save_id_i] <= entry_q[tos_q];
    end
  end
`else
  logic unused_ckpt;

  assign do_flush    = flush_i | ckpt_restore_i;
  assign do_restore  = 1'b0;
  assign rest_tos    = '0;
  assign rest_cnt    = '0;
  assign rest_top    = '0;
  assign unused_ckpt = ckpt_save_i ^ (^ckpt_save_id_i) ^ (^ckpt_restore_id_i);
`endif

  // Push+pop on an empty stack degrades to a plain push.
  assign do_replace = ~do_flush & ~do_restore & push_i & pop_i & (count_q != '0);
  assign do_push    = ~do_flush & ~do_restore & push_i & ~do_replace;
  assign do_pop     = ~do_flush & ~do_restore & pop_i & ~push_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) entry_q[i] <= '0;
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (do_flush) begin
        tos_q   <= '0;
        count_q <= '0;
      end else if (do_restore) begin
        tos_q             <= rest_tos;
        count_q           <= rest_cnt;
        entry_q[rest_tos] <= rest_top;
      end else if (do_replace) begin
        entry_q[tos_q] <= push_addr_i;
      end else if (do_push) begin
        tos_q            <= tos_inc;
        entry_q[tos_inc] <= push_addr_i;
        if (count_q == FULL) overflow_q <= 1'b1;
        else count_q <= count_q + 1'b1;
      end else if (do_pop) begin
        if (count_q != '0) begin
          tos_q   <= tos_dec;
          count_q <= count_q - 1'b1;
        end else begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  assign top_addr_o  = entry_q[tos_q];
  assign top_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule
